// File: rtl/rs_issue_queue.sv
// Unified reservation station: holds dispatched micro-ops in age order, captures operands from the
// completion broadcast and issues at most one ready op per cycle to either the ALU or the LS port.
module rs_issue_queue #(
    parameter int RS_ENTRIES   = 8,
    parameter int GPR_SIZE     = 64,
    parameter int ROB_IDX_SIZE = 4
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic                          in_flush,
    input  logic                          in_dispatch_valid,
    output logic                          out_dispatch_ready,
    input  logic                          in_dispatch_is_ls,
    input  logic [3:0]                    in_dispatch_fu_op,
    input  logic                          in_dispatch_a_valid,
    input  logic                          in_dispatch_b_valid,
    input  logic [ROB_IDX_SIZE-1:0]       in_dispatch_a_tag,
    input  logic [ROB_IDX_SIZE-1:0]       in_dispatch_b_tag,
    input  logic [GPR_SIZE-1:0]           in_dispatch_val_a,
    input  logic [GPR_SIZE-1:0]           in_dispatch_val_b,
    input  logic                          in_dispatch_nzcv_valid,
    input  logic [ROB_IDX_SIZE-1:0]       in_dispatch_nzcv_tag,
    input  logic [3:0]                    in_dispatch_nzcv,
    input  logic                          in_dispatch_set_nzcv,
    input  logic [3:0]                    in_dispatch_cond,
    input  logic [ROB_IDX_SIZE-1:0]       in_dispatch_dst_rob_index,
    input  logic                          in_bcast_done,
    input  logic [ROB_IDX_SIZE-1:0]       in_bcast_rob_index,
    input  logic [GPR_SIZE-1:0]           in_bcast_value,
    input  logic                          in_bcast_set_nzcv,
    input  logic [3:0]                    in_bcast_nzcv,
    input  logic                          in_fu_alu_ready,
    input  logic                          in_fu_ls_ready,
    output logic                          out_alu_start,
    output logic [3:0]                    out_alu_fu_op,
    output logic [GPR_SIZE-1:0]           out_alu_val_a,
    output logic [GPR_SIZE-1:0]           out_alu_val_b,
    output logic [ROB_IDX_SIZE-1:0]       out_alu_dst_rob_index,
    output logic                          out_alu_set_nzcv,
    output logic [3:0]                    out_alu_nzcv,
    output logic [3:0]                    out_alu_cond,
    output logic                          out_ls_start,
    output logic [3:0]                    out_ls_fu_op,
    output logic [GPR_SIZE-1:0]           out_ls_val_a,
    output logic [GPR_SIZE-1:0]           out_ls_val_b,
    output logic [ROB_IDX_SIZE-1:0]       out_ls_dst_rob_index,
    output logic [$clog2(RS_ENTRIES):0]   out_count
);
    localparam int IW = $clog2(RS_ENTRIES);
    localparam int CW = IW + 1;

    typedef struct packed {
        logic                    is_ls;
        logic [3:0]              op;
        logic                    a_valid;
        logic [ROB_IDX_SIZE-1:0] a_tag;
        logic [GPR_SIZE-1:0]     a_val;
        logic                    b_valid;
        logic [ROB_IDX_SIZE-1:0] b_tag;
        logic [GPR_SIZE-1:0]     b_val;
        logic                    f_valid;
        logic [ROB_IDX_SIZE-1:0] f_tag;
        logic [3:0]              f_val;
        logic                    set_nzcv;
        logic [3:0]              cond;
        logic [ROB_IDX_SIZE-1:0] dst;
    } entry_t;

    // Slot i is occupied iff i < count_q; slot 0 is the oldest op.
    entry_t          ent_q [RS_ENTRIES];
    entry_t          ent_d [RS_ENTRIES];
    entry_t          new_ent;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   cnt_after;
    logic            accept;
    logic            alu_found, ls_seen, ls_found;
    logic [IW-1:0]   alu_idx, ls_idx, iss_idx;
    logic            alu_ok, ls_ok, issue_alu, issue_ls, do_issue, cooldown;

    function automatic entry_t wake(input entry_t e, input logic done,
                                    input logic [ROB_IDX_SIZE-1:0] idx,
                                    input logic [GPR_SIZE-1:0] val,
                                    input logic setf, input logic [3:0] nzcv);
        entry_t r;
        r = e;
        if (done) begin
            if (!r.a_valid && r.a_tag == idx) begin
                r.a_valid = 1'b1;
                r.a_val   = val;
            end
            if (!r.b_valid && r.b_tag == idx) begin
                r.b_valid = 1'b1;
                r.b_val   = val;
            end
            if (setf && !r.f_valid && r.f_tag == idx) begin
                r.f_valid = 1'b1;
                r.f_val   = nzcv;
            end
        end
        return r;
    endfunction

    assign out_count          = count_q;
    assign out_dispatch_ready = (count_q < CW'(RS_ENTRIES));
    assign cooldown           = out_alu_start | out_ls_start;

    // Candidate selection on the pre-edge contents; LS is only considered at its oldest entry.
    always_comb begin
        alu_found = 1'b0;
        alu_idx   = '0;
        ls_seen   = 1'b0;
        ls_found  = 1'b0;
        ls_idx    = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (CW'(i) < count_q) begin
                if (!ent_q[i].is_ls) begin
                    if (!alu_found && ent_q[i].a_valid && ent_q[i].b_valid && ent_q[i].f_valid) begin
                        alu_found = 1'b1;
                        alu_idx   = IW'(i);
                    end
                end else if (!ls_seen) begin
                    ls_seen  = 1'b1;
                    ls_found = ent_q[i].a_valid && ent_q[i].b_valid;
                    ls_idx   = IW'(i);
                end
            end
        end
        alu_ok    = alu_found && in_fu_alu_ready && !cooldown;
        ls_ok     = ls_found && in_fu_ls_ready && !cooldown;
        issue_alu = alu_ok && (!ls_ok || alu_idx < ls_idx);
        issue_ls  = ls_ok && !issue_alu;
        do_issue  = issue_alu || issue_ls;
        iss_idx   = issue_alu ? alu_idx : ls_idx;
    end

    always_comb begin
        new_ent.is_ls    = in_dispatch_is_ls;
        new_ent.op       = in_dispatch_fu_op;
        new_ent.a_valid  = in_dispatch_a_valid;
        new_ent.a_tag    = in_dispatch_a_tag;
        new_ent.a_val    = in_dispatch_val_a;
        new_ent.b_valid  = in_dispatch_b_valid;
        new_ent.b_tag    = in_dispatch_b_tag;
        new_ent.b_val    = in_dispatch_val_b;
        new_ent.f_valid  = in_dispatch_nzcv_valid;
        new_ent.f_tag    = in_dispatch_nzcv_tag;
        new_ent.f_val    = in_dispatch_nzcv;
        new_ent.set_nzcv = in_dispatch_set_nzcv;
        new_ent.cond     = in_dispatch_cond;
        new_ent.dst      = in_dispatch_dst_rob_index;
    end

    // Collapse over the issued slot, apply wakeup, then append the dispatched op behind the survivors.
    always_comb begin
        accept    = in_dispatch_valid && out_dispatch_ready;
        cnt_after = count_q - CW'(do_issue);
        for (int i = 0; i < RS_ENTRIES; i++) begin
            int nxt;
            nxt = (i == RS_ENTRIES - 1) ? i : i + 1;
            if (do_issue && IW'(i) >= iss_idx)
                ent_d[i] = wake(ent_q[nxt], in_bcast_done, in_bcast_rob_index, in_bcast_value,
                                in_bcast_set_nzcv, in_bcast_nzcv);
            else
                ent_d[i] = wake(ent_q[i], in_bcast_done, in_bcast_rob_index, in_bcast_value,
                                in_bcast_set_nzcv, in_bcast_nzcv);
        end
        if (accept)
            ent_d[cnt_after[IW-1:0]] = wake(new_ent, in_bcast_done, in_bcast_rob_index,
                                            in_bcast_value, in_bcast_set_nzcv, in_bcast_nzcv);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            count_q               <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) ent_q[i] <= '0;
            out_alu_start         <= 1'b0;
            out_alu_fu_op         <= '0;
            out_alu_val_a         <= '0;
            out_alu_val_b         <= '0;
            out_alu_dst_rob_index <= '0;
            out_alu_set_nzcv      <= 1'b0;
            out_alu_nzcv          <= '0;
            out_alu_cond          <= '0;
            out_ls_start          <= 1'b0;
            out_ls_fu_op          <= '0;
            out_ls_val_a          <= '0;
            out_ls_val_b          <= '0;
            out_ls_dst_rob_index  <= '0;
        end else if (in_flush) begin
            count_q       <= '0;
            out_alu_start <= 1'b0;
            out_ls_start  <= 1'b0;
        end else begin
            count_q       <= cnt_after + CW'(accept);
            for (int i = 0; i < RS_ENTRIES; i++) ent_q[i] <= ent_d[i];
            out_alu_start <= issue_alu;
            out_ls_start  <= issue_ls;
            if (issue_alu) begin
                out_alu_fu_op         <= ent_q[iss_idx].op;
                out_alu_val_a         <= ent_q[iss_idx].a_val;
                out_alu_val_b         <= ent_q[iss_idx].b_val;
                out_alu_dst_rob_index <= ent_q[iss_idx].dst;
                out_alu_set_nzcv      <= ent_q[iss_idx].set_nzcv;
                out_alu_nzcv          <= ent_q[iss_idx].f_val;
                out_alu_cond          <= ent_q[iss_idx].cond;
            end
            if (issue_ls) begin
                out_ls_fu_op         <= ent_q[iss_idx].op;
                out_ls_val_a         <= ent_q[iss_idx].a_val;
                out_ls_val_b         <= ent_q[iss_idx].b_val;
                out_ls_dst_rob_index <= ent_q[iss_idx].dst;
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_queue.sv
// Bench for rs_issue_queue: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a queue-based model of the reservation station.
module tb_rs_issue_queue;
    localparam int N = 8;
    localparam int G = 64;
    localparam int R = 4;

    logic in_clk = 1'b0;
    logic in_rst_n = 1'b0;
    logic in_flush = 1'b0;
    logic in_dispatch_valid = 1'b0;
    logic out_dispatch_ready;
    logic in_dispatch_is_ls = 1'b0;
    logic [3:0] in_dispatch_fu_op = '0;
    logic in_dispatch_a_valid = 1'b0, in_dispatch_b_valid = 1'b0;
    logic [R-1:0] in_dispatch_a_tag = '0, in_dispatch_b_tag = '0;
    logic [G-1:0] in_dispatch_val_a = '0, in_dispatch_val_b = '0;
    logic in_dispatch_nzcv_valid = 1'b0;
    logic [R-1:0] in_dispatch_nzcv_tag = '0;
    logic [3:0] in_dispatch_nzcv = '0;
    logic in_dispatch_set_nzcv = 1'b0;
    logic [3:0] in_dispatch_cond = '0;
    logic [R-1:0] in_dispatch_dst_rob_index = '0;
    logic in_bcast_done = 1'b0;
    logic [R-1:0] in_bcast_rob_index = '0;
    logic [G-1:0] in_bcast_value = '0;
    logic in_bcast_set_nzcv = 1'b0;
    logic [3:0] in_bcast_nzcv = '0;
    logic in_fu_alu_ready = 1'b0, in_fu_ls_ready = 1'b0;
    logic out_alu_start, out_alu_set_nzcv, out_ls_start;
    logic [3:0] out_alu_fu_op, out_alu_nzcv, out_alu_cond, out_ls_fu_op;
    logic [G-1:0] out_alu_val_a, out_alu_val_b, out_ls_val_a, out_ls_val_b;
    logic [R-1:0] out_alu_dst_rob_index, out_ls_dst_rob_index;
    logic [$clog2(N):0] out_count;

    rs_issue_queue #(.RS_ENTRIES(N), .GPR_SIZE(G), .ROB_IDX_SIZE(R)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_flush(in_flush),
        .in_dispatch_valid(in_dispatch_valid), .out_dispatch_ready(out_dispatch_ready),
        .in_dispatch_is_ls(in_dispatch_is_ls), .in_dispatch_fu_op(in_dispatch_fu_op),
        .in_dispatch_a_valid(in_dispatch_a_valid), .in_dispatch_b_valid(in_dispatch_b_valid),
        .in_dispatch_a_tag(in_dispatch_a_tag), .in_dispatch_b_tag(in_dispatch_b_tag),
        .in_dispatch_val_a(in_dispatch_val_a), .in_dispatch_val_b(in_dispatch_val_b),
        .in_dispatch_nzcv_valid(in_dispatch_nzcv_valid), .in_dispatch_nzcv_tag(in_dispatch_nzcv_tag),
        .in_dispatch_nzcv(in_dispatch_nzcv), .in_dispatch_set_nzcv(in_dispatch_set_nzcv),
        .in_dispatch_cond(in_dispatch_cond), .in_dispatch_dst_rob_index(in_dispatch_dst_rob_index),
        .in_bcast_done(in_bcast_done), .in_bcast_rob_index(in_bcast_rob_index),
        .in_bcast_value(in_bcast_value), .in_bcast_set_nzcv(in_bcast_set_nzcv),
        .in_bcast_nzcv(in_bcast_nzcv), .in_fu_alu_ready(in_fu_alu_ready),
        .in_fu_ls_ready(in_fu_ls_ready), .out_alu_start(out_alu_start),
        .out_alu_fu_op(out_alu_fu_op), .out_alu_val_a(out_alu_val_a), .out_alu_val_b(out_alu_val_b),
        .out_alu_dst_rob_index(out_alu_dst_rob_index), .out_alu_set_nzcv(out_alu_set_nzcv),
        .out_alu_nzcv(out_alu_nzcv), .out_alu_cond(out_alu_cond), .out_ls_start(out_ls_start),
        .out_ls_fu_op(out_ls_fu_op), .out_ls_val_a(out_ls_val_a), .out_ls_val_b(out_ls_val_b),
        .out_ls_dst_rob_index(out_ls_dst_rob_index), .out_count(out_count)
    );

    // ---------------- clock / reset ----------------
    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [R-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic         is_ls;
        logic [3:0]   op;
        logic         av, bv, fv;
        logic [R-1:0] at, bt, ft;
        logic [G-1:0] a, b;
        logic [3:0]   f;
        logic         setf;
        logic [3:0]   cond;
        logic [R-1:0] dst;
    } m_ent_t;

    m_ent_t m_q[$];
    m_ent_t m_new;
    logic m_cool = 1'b0;
    logic e_alu_start = 1'b0, e_ls_start = 1'b0, e_alu_setf = 1'b0;
    logic [3:0] e_alu_op = '0, e_alu_nzcv = '0, e_alu_cond = '0, e_ls_op = '0;
    logic [G-1:0] e_alu_a = '0, e_alu_b = '0, e_ls_a = '0, e_ls_b = '0;
    logic [R-1:0] e_alu_dst = '0, e_ls_dst = '0;
    int m_alu_i, m_ls_i, m_pick;
    logic m_pick_ls, m_acc;

    function automatic m_ent_t m_wake(input m_ent_t e);
        m_ent_t r;
        r = e;
        if (in_bcast_done) begin
            if (!r.av && r.at == in_bcast_rob_index) begin r.av = 1'b1; r.a = in_bcast_value; end
            if (!r.bv && r.bt == in_bcast_rob_index) begin r.bv = 1'b1; r.b = in_bcast_value; end
            if (in_bcast_set_nzcv && !r.fv && r.ft == in_bcast_rob_index) begin
                r.fv = 1'b1;
                r.f  = in_bcast_nzcv;
            end
        end
        return r;
    endfunction

    always @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            m_q.delete();
            m_cool = 1'b0;
            e_alu_start = 1'b0; e_ls_start = 1'b0; e_alu_setf = 1'b0;
            e_alu_op = '0; e_alu_nzcv = '0; e_alu_cond = '0; e_ls_op = '0;
            e_alu_a = '0; e_alu_b = '0; e_ls_a = '0; e_ls_b = '0;
            e_alu_dst = '0; e_ls_dst = '0;
        end else if (in_flush) begin
            m_q.delete();
            m_cool = 1'b0;
            e_alu_start = 1'b0;
            e_ls_start = 1'b0;
        end else begin
            m_alu_i = -1;
            m_ls_i = -1;
            for (int i = 0; i < m_q.size(); i++)
                if (m_alu_i < 0 && !m_q[i].is_ls && m_q[i].av && m_q[i].bv && m_q[i].fv) m_alu_i = i;
            for (int i = 0; i < m_q.size(); i++) begin
                if (m_q[i].is_ls) begin
                    if (m_q[i].av && m_q[i].bv) m_ls_i = i;
                    break;
                end
            end
            if (m_cool || !in_fu_alu_ready) m_alu_i = -1;
            if (m_cool || !in_fu_ls_ready) m_ls_i = -1;
            m_pick = -1;
            m_pick_ls = 1'b0;
            if (m_alu_i >= 0 && (m_ls_i < 0 || m_alu_i < m_ls_i)) m_pick = m_alu_i;
            else if (m_ls_i >= 0) begin m_pick = m_ls_i; m_pick_ls = 1'b1; end
            m_acc = in_dispatch_valid && (m_q.size() < N);
            m_new = '{is_ls: in_dispatch_is_ls, op: in_dispatch_fu_op,
                      av: in_dispatch_a_valid, bv: in_dispatch_b_valid, fv: in_dispatch_nzcv_valid,
                      at: in_dispatch_a_tag, bt: in_dispatch_b_tag, ft: in_dispatch_nzcv_tag,
                      a: in_dispatch_val_a, b: in_dispatch_val_b, f: in_dispatch_nzcv,
                      setf: in_dispatch_set_nzcv, cond: in_dispatch_cond,
                      dst: in_dispatch_dst_rob_index};
            e_alu_start = (m_pick >= 0) && !m_pick_ls;
            e_ls_start  = (m_pick >= 0) && m_pick_ls;
            if (e_alu_start) begin
                e_alu_op = m_q[m_pick].op; e_alu_a = m_q[m_pick].a; e_alu_b = m_q[m_pick].b;
                e_alu_dst = m_q[m_pick].dst; e_alu_setf = m_q[m_pick].setf;
                e_alu_nzcv = m_q[m_pick].f; e_alu_cond = m_q[m_pick].cond;
            end
            if (e_ls_start) begin
                e_ls_op = m_q[m_pick].op; e_ls_a = m_q[m_pick].a; e_ls_b = m_q[m_pick].b;
                e_ls_dst = m_q[m_pick].dst;
            end
            if (m_pick >= 0) m_q.delete(m_pick);
            for (int i = 0; i < m_q.size(); i++) m_q[i] = m_wake(m_q[i]);
            if (m_acc) m_q.push_back(m_wake(m_new));
            m_cool = (m_pick >= 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(posedge in_clk) begin
        #1;
        chk("count", out_count, m_q.size());
        chk("dispatch_ready", out_dispatch_ready, m_q.size() < N);
        chk("alu_start", out_alu_start, e_alu_start);
        chk("ls_start", out_ls_start, e_ls_start);
        chk("one_start", out_alu_start & out_ls_start, 0);
        chk("alu_op", out_alu_fu_op, e_alu_op);
        chk("alu_val_a", out_alu_val_a, e_alu_a);
        chk("alu_val_b", out_alu_val_b, e_alu_b);
        chk("alu_dst", out_alu_dst_rob_index, e_alu_dst);
        chk("alu_set_nzcv", out_alu_set_nzcv, e_alu_setf);
        chk("alu_nzcv", out_alu_nzcv, e_alu_nzcv);
        chk("alu_cond", out_alu_cond, e_alu_cond);
        chk("ls_op", out_ls_fu_op, e_ls_op);
        chk("ls_val_a", out_ls_val_a, e_ls_a);
        chk("ls_val_b", out_ls_val_b, e_ls_b);
        chk("ls_dst", out_ls_dst_rob_index, e_ls_dst);
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        in_dispatch_valid = 1'b0;
        in_bcast_done = 1'b0;
        in_flush = 1'b0;
    endtask

    task automatic disp(input logic is_ls, input logic [3:0] op,
                        input logic av, input logic [R-1:0] at, input logic [G-1:0] a,
                        input logic bv, input logic [R-1:0] bt, input logic [G-1:0] b,
                        input logic fv, input logic [R-1:0] dst);
        in_dispatch_valid = 1'b1;
        in_dispatch_is_ls = is_ls;
        in_dispatch_fu_op = op;
        in_dispatch_a_valid = av; in_dispatch_a_tag = at; in_dispatch_val_a = a;
        in_dispatch_b_valid = bv; in_dispatch_b_tag = bt; in_dispatch_val_b = b;
        in_dispatch_nzcv_valid = fv; in_dispatch_nzcv_tag = '0; in_dispatch_nzcv = '0;
        in_dispatch_set_nzcv = 1'b0; in_dispatch_cond = '0;
        in_dispatch_dst_rob_index = dst;
    endtask

    task automatic bcast(input logic [R-1:0] idx, input logic [G-1:0] val);
        in_bcast_done = 1'b1;
        in_bcast_rob_index = idx;
        in_bcast_value = val;
        in_bcast_set_nzcv = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int last;
        int alu_seen;
        int ls_seen;
        logic found;

        in_rst_n = 1'b0;
        repeat (3) @(negedge in_clk);
        chk("rst_count", out_count, 0);
        chk("rst_ready", out_dispatch_ready, 1);
        chk("rst_alu_start", out_alu_start, 0);
        chk("rst_ls_start", out_ls_start, 0);
        chk("rst_alu_val_a", out_alu_val_a, 0);
        in_rst_n = 1'b1;
        in_fu_alu_ready = 1'b1;
        in_fu_ls_ready = 1'b1;

        // single ready ALU op
        disp(1'b0, 4'd1, 1'b1, 4'd0, 64'd5, 1'b1, 4'd0, 64'd7, 1'b1, 4'd3);
        @(negedge in_clk);
        idle();
        chk("t1_count1", out_count, 1);
        chk("t1_no_start_yet", out_alu_start, 0);
        @(negedge in_clk);
        chk("t1_start", out_alu_start, 1);
        chk("t1_val_a", out_alu_val_a, 5);
        chk("t1_val_b", out_alu_val_b, 7);
        chk("t1_dst", out_alu_dst_rob_index, 3);
        chk("t1_count0", out_count, 0);
        @(negedge in_clk);
        chk("t1_pulse_end", out_alu_start, 0);
        chk("t1_hold_a", out_alu_val_a, 5);

        // wakeup via broadcast, issue only on the following cycle
        disp(1'b0, 4'd2, 1'b0, 4'd2, 64'd0, 1'b1, 4'd0, 64'd1, 1'b1, 4'd4);
        @(negedge in_clk);
        idle();
        chk("t2_wait", out_alu_start, 0);
        bcast(4'd2, 64'h10);
        @(negedge in_clk);
        idle();
        chk("t2_not_before", out_alu_start, 0);
        @(negedge in_clk);
        chk("t2_start", out_alu_start, 1);
        chk("t2_val_a", out_alu_val_a, 64'h10);

        // same-cycle dispatch and broadcast
        @(negedge in_clk);
        disp(1'b0, 4'd3, 1'b0, 4'd6, 64'd0, 1'b1, 4'd0, 64'd2, 1'b1, 4'd5);
        bcast(4'd6, 64'd9);
        @(negedge in_clk);
        idle();
        @(negedge in_clk);
        chk("t3_start", out_alu_start, 1);
        chk("t3_val_a", out_alu_val_a, 9);
        @(negedge in_clk);

        // fill to capacity, then drain oldest-first every other cycle
        for (int i = 0; i < N; i++) begin
            chk("t4_ready_fill", out_dispatch_ready, 1);
            disp(1'b0, 4'd1, 1'b0, 4'd5, 64'd0, 1'b1, 4'd0, 64'(i), 1'b1, R'(i));
            exp_q.push_back(R'(i));
            @(negedge in_clk);
        end
        chk("t4_full_ready", out_dispatch_ready, 0);
        chk("t4_full_count", out_count, 8);
        disp(1'b0, 4'd1, 1'b1, 4'd0, 64'd0, 1'b1, 4'd0, 64'd0, 1'b1, 4'd9);
        @(negedge in_clk);
        idle();
        chk("t4_ninth_ignored", out_count, 8);
        bcast(4'd5, 64'h55);
        @(negedge in_clk);
        idle();
        last = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge in_clk);
            if (out_alu_start) begin
                if (exp_q.size() == 0) chk("t4_extra_issue", 1, 0);
                else chk("t4_order", out_alu_dst_rob_index, exp_q.pop_front());
                if (last >= 0) chk("t4_gap", cyc - last, 2);
                last = cyc;
            end
        end
        chk("t4_drained", exp_q.size(), 0);
        chk("t4_count0", out_count, 0);
        exp_q.delete();

        // LS ordering: pending LS0 blocks LS1, ALU0 bypasses
        disp(1'b1, 4'd7, 1'b0, 4'd9, 64'd0, 1'b1, 4'd0, 64'd1, 1'b0, 4'd10);
        @(negedge in_clk);
        disp(1'b1, 4'd8, 1'b1, 4'd0, 64'd2, 1'b1, 4'd0, 64'd3, 1'b0, 4'd11);
        @(negedge in_clk);
        disp(1'b0, 4'd1, 1'b1, 4'd0, 64'd4, 1'b1, 4'd0, 64'd5, 1'b1, 4'd12);
        @(negedge in_clk);
        idle();
        alu_seen = 0;
        ls_seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge in_clk);
            if (out_alu_start) begin
                alu_seen++;
                chk("t5_alu_dst", out_alu_dst_rob_index, 12);
            end
            if (out_ls_start) ls_seen++;
        end
        chk("t5_alu_once", alu_seen, 1);
        chk("t5_ls_blocked", ls_seen, 0);
        exp_q.push_back(4'd10);
        exp_q.push_back(4'd11);
        bcast(4'd9, 64'h99);
        @(negedge in_clk);
        idle();
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge in_clk);
            if (out_ls_start) begin
                if (exp_q.size() == 0) chk("t5_ls_extra", 1, 0);
                else chk("t5_ls_order", out_ls_dst_rob_index, exp_q.pop_front());
            end
        end
        chk("t5_ls_drained", exp_q.size(), 0);
        exp_q.delete();

        // flush with 5 entries
        for (int i = 0; i < 5; i++) begin
            disp(1'b0, 4'd1, 1'b0, 4'd14, 64'd0, 1'b1, 4'd0, 64'd0, 1'b1, R'(i));
            @(negedge in_clk);
        end
        chk("t6_five", out_count, 5);
        in_flush = 1'b1;
        disp(1'b0, 4'd1, 1'b1, 4'd0, 64'd1, 1'b1, 4'd0, 64'd1, 1'b1, 4'd8);
        @(negedge in_clk);
        idle();
        chk("t6_flush_count", out_count, 0);
        chk("t6_flush_alu", out_alu_start, 0);
        chk("t6_flush_ls", out_ls_start, 0);

        // async reset during a start pulse
        disp(1'b0, 4'd1, 1'b1, 4'd0, 64'd1, 1'b1, 4'd0, 64'd2, 1'b1, 4'd7);
        @(negedge in_clk);
        idle();
        found = 1'b0;
        for (int cyc = 0; cyc < 10 && !found; cyc++) begin
            @(negedge in_clk);
            if (out_alu_start) found = 1'b1;
        end
        chk("t7_start_seen", found, 1);
        in_rst_n = 1'b0;
        #1;
        chk("t7_async_start", out_alu_start, 0);
        chk("t7_async_count", out_count, 0);
        @(negedge in_clk);
        in_rst_n = 1'b1;

        // random traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_dispatch_valid = ($urandom_range(0, 3) != 0);
            in_dispatch_is_ls = $urandom_range(0, 1);
            in_dispatch_fu_op = 4'($urandom);
            in_dispatch_a_valid = $urandom_range(0, 1);
            in_dispatch_b_valid = $urandom_range(0, 1);
            in_dispatch_a_tag = R'($urandom_range(0, 7));
            in_dispatch_b_tag = R'($urandom_range(0, 7));
            in_dispatch_val_a = {$urandom, $urandom};
            in_dispatch_val_b = {$urandom, $urandom};
            in_dispatch_nzcv_valid = $urandom_range(0, 1);
            in_dispatch_nzcv_tag = R'($urandom_range(0, 7));
            in_dispatch_nzcv = 4'($urandom);
            in_dispatch_set_nzcv = $urandom_range(0, 1);
            in_dispatch_cond = 4'($urandom);
            in_dispatch_dst_rob_index = R'($urandom);
            in_bcast_done = $urandom_range(0, 1);
            in_bcast_rob_index = R'($urandom_range(0, 7));
            in_bcast_value = {$urandom, $urandom};
            in_bcast_set_nzcv = $urandom_range(0, 1);
            in_bcast_nzcv = 4'($urandom);
            in_fu_alu_ready = ($urandom_range(0, 4) != 0);
            in_fu_ls_ready = ($urandom_range(0, 4) != 0);
            in_flush = ($urandom_range(0, 63) == 0);
            @(negedge in_clk);
        end
        idle();
        @(negedge in_clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rs_issue_queue.md
Name: rs_issue_queue

Overview:
- Unified reservation station: the initiator side of the RS->FU issue handshake.
- Accepts dispatched micro-ops from the rename/dispatch stage and holds them until all operands are available.
- Captures operands from the single FU->ROB completion broadcast and issues at most one op per cycle, either to the ALU port or to the LS port.
- The FU result path is shared, so ALU and LS are never started in the same cycle.

Parameters:
- RS_ENTRIES, 8, number of queue entries (power of two, >=2).
- GPR_SIZE, 64, operand/value width.
- ROB_IDX_SIZE, 4, ROB tag width.

Ports:
- in_clk  input  1  clock, all state on posedge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_flush  input  1  mispredict flush; empties queue.
- in_dispatch_valid  input  1  dispatch request this cycle.
- out_dispatch_ready  output  1  queue can accept this cycle.
- in_dispatch_is_ls  input  1  1 = LS op, 0 = ALU op.
- in_dispatch_fu_op  input  fu_op_t  operation.
- in_dispatch_a_valid / in_dispatch_b_valid  input  1 each  operand already known.
- in_dispatch_a_tag / in_dispatch_b_tag  input  ROB_IDX_SIZE each  producer ROB tag if not valid.
- in_dispatch_val_a / in_dispatch_val_b  input  GPR_SIZE each  operand value if valid.
- in_dispatch_nzcv_valid, in_dispatch_nzcv_tag, in_dispatch_nzcv  input  1 / ROB_IDX_SIZE / 4  flags source.
- in_dispatch_set_nzcv  input  1  op writes flags.
- in_dispatch_cond  input  cond_t  condition code.
- in_dispatch_dst_rob_index  input  ROB_IDX_SIZE  destination tag.
- in_bcast_done, in_bcast_rob_index, in_bcast_value, in_bcast_set_nzcv, in_bcast_nzcv  input  1/ROB_IDX_SIZE/GPR_SIZE/1/4  FU completion broadcast.
- in_fu_alu_ready, in_fu_ls_ready  input  1 each  FU can accept.
- out_alu_start, out_alu_fu_op, out_alu_val_a, out_alu_val_b, out_alu_dst_rob_index, out_alu_set_nzcv, out_alu_nzcv, out_alu_cond  output  ALU issue bundle.
- out_ls_start, out_ls_fu_op, out_ls_val_a, out_ls_val_b, out_ls_dst_rob_index  output  LS issue bundle.
- out_count  output  $clog2(RS_ENTRIES)+1  occupied entries.

Behaviour:
- Reset (async, in_rst_n=0): all entries invalid.
  - out_count=0, out_dispatch_ready=1.
  - out_alu_start=0, out_ls_start=0.
  - All issue data outputs 0.
- Entry state: valid, is_ls, op, a/b (valid, tag, value), nzcv (valid, tag, value), set_nzcv, cond, dst. Age order equals dispatch order.
- Dispatch:
  - Accepted on posedge when in_dispatch_valid && out_dispatch_ready.
  - out_dispatch_ready = (count < RS_ENTRIES) combinationally.
  - An entry freed by issue in the same cycle does not count as free.
- Wakeup:
  - On posedge with in_bcast_done, every valid entry whose pending a/b tag equals in_bcast_rob_index captures in_bcast_value and sets that operand valid.
  - A pending nzcv source captures in_bcast_nzcv only if in_bcast_set_nzcv.
  - A dispatching entry also snoops the same-cycle broadcast, so no wakeup is lost.
- Readiness:
  - ALU entry: a, b and nzcv valid.
  - LS entry: a and b valid.
- Issue selection (evaluated on pre-edge state, result registered):
  - ALU candidate: oldest ready ALU entry.
  - LS candidate: oldest LS entry only (LS strictly in order), if ready.
  - When both are possible, the older of the two wins; one issue per cycle.
  - An ALU issue requires in_fu_alu_ready=1; an LS issue requires in_fu_ls_ready=1.
  - No issue in the cycle following any issue: start is a 1-cycle pulse and the FU ready drop lags by one cycle.
- Issue output:
  - On the issue edge the selected bundle is registered and the chosen start is driven high for exactly one cycle, then low.
  - The entry is deallocated on the same edge; younger entries keep their order.
  - Data outputs hold their last value while start=0.
- Flush (in_flush=1 at posedge): all entries invalid, no dispatch accepted, no issue; starts are 0 on the next cycle. Flush takes priority over dispatch, wakeup and issue.
- Count: next = count + accept - issue; never exceeds RS_ENTRIES and never underflows.
- Reset mid-issue: start deasserts immediately (async).

Test Plan:
- Reset, then dispatch ALU PLUS with a=5, b=7 both valid, dst=3, fu ready -> out_alu_start=1 for exactly 1 cycle, val_a=5, val_b=7, dst=3; out_count returns to 0.
- Dispatch ALU op with a pending on tag 2; broadcast done, idx=2, value=0x10 -> issue occurs on the following cycle with val_a=0x10, not before.
- Same-cycle dispatch (a pending on tag 6) and broadcast idx=6, value=9 -> entry captures 9 and issues with val_a=9.
- Fill 8 entries all pending -> out_dispatch_ready=0, a 9th dispatch is ignored, out_count=8. Broadcast the shared tag -> issues drain oldest-first, one op every 2 cycles.
- LS0 (pending) older than LS1 (ready) and ALU0 (ready) -> ALU0 issues, LS1 does not. After LS0 wakes up -> LS0 issues before LS1. out_alu_start and out_ls_start are never 1 together.
- 5 entries valid, in_flush=1 -> out_count=0 and no start on the next cycle. Asserting in_rst_n=0 during a start pulse -> start drops immediately.
